// File: rtl/mmio_input_port.sv
// Memory-mapped input port: synchronizes SW/KEY, debounces keys, latches sticky key events.
// Optional macro MMIO_IN_RELEASE_EVT_EN adds release events in evt[7:4].
module mmio_input_port #(
  parameter int                    DATA_WIDTH      = 16,
  parameter int                    ADDR_WIDTH      = 16,
  parameter logic [ADDR_WIDTH-1:0] SW_ADDR         = 16'hFF00,
  parameter logic [ADDR_WIDTH-1:0] KEY_ADDR        = 16'hFF01,
  parameter logic [ADDR_WIDTH-1:0] KEYEVT_ADDR     = 16'hFF02,
  parameter int                    DEBOUNCE_CYCLES = 4
) (
  input  logic                  I_CLOCK,
  input  logic                  I_LOCK,
  input  logic [9:0]            I_SW,
  input  logic [3:0]            I_KEY,
  input  logic                  I_ReadEnable,
  input  logic [ADDR_WIDTH-1:0] I_ReadAddr,
  output logic [DATA_WIDTH-1:0] O_ReadData,
  output logic                  O_ReadValid,
  output logic                  O_KeyEventPending
);

  localparam logic [0:0] ST_UP   = 1'b0;
  localparam logic [0:0] ST_DOWN = 1'b1;
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

`ifdef MMIO_IN_RELEASE_EVT_EN
  localparam int EVT_W = 8;
`else
  localparam int EVT_W = 4;
`endif

  logic [9:0]            sw_meta_q, sw_meta_d;
  logic [9:0]            sw_sync_q, sw_sync_d;
  logic [3:0]            key_meta_q, key_meta_d;
  logic [3:0]            key_sync_q, key_sync_d;
  logic [3:0]            kstate_q, kstate_d;
  logic [7:0]            cnt_q [4];
  logic [7:0]            cnt_d [4];
  logic [3:0]            key_pressed;
  logic [3:0]            press;
  logic [EVT_W-1:0]      evt_q, evt_d;
  logic [EVT_W-1:0]      evt_set;
  logic [EVT_W-1:0]      evt_clr;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  pending_q, pending_d;
  logic                  hit_sw, hit_key, hit_evt;
`ifdef MMIO_IN_RELEASE_EVT_EN
  logic [3:0]            rel_pulse;
`endif

  always_comb begin
    sw_meta_d  = I_SW;
    sw_sync_d  = sw_meta_q;
    key_meta_d = I_KEY;
    key_sync_d = key_meta_q;
  end

  assign key_pressed = ~key_sync_q;

  // Each key must hold a new level for DEBOUNCE_CYCLES samples before its state flips.
  always_comb begin
    kstate_d = kstate_q;
    press    = '0;
`ifdef MMIO_IN_RELEASE_EVT_EN
    rel_pulse = '0;
`endif
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      case (kstate_q[i])
        ST_UP: begin
          if (key_pressed[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
              kstate_d[i] = ST_DOWN;
              cnt_d[i]    = '0;
              press[i]    = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + 8'd1;
            end
          end else begin
            cnt_d[i] = '0;
          end
        end
        default: begin
          if (!key_pressed[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
              kstate_d[i] = ST_UP;
              cnt_d[i]    = '0;
`ifdef MMIO_IN_RELEASE_EVT_EN
              rel_pulse[i] = 1'b1;
`endif
            end else begin
              cnt_d[i] = cnt_q[i] + 8'd1;
            end
          end else begin
            cnt_d[i] = '0;
          end
        end
      endcase
    end
  end

  assign hit_sw  = I_ReadEnable && (I_ReadAddr == SW_ADDR);
  assign hit_key = I_ReadEnable && (I_ReadAddr == KEY_ADDR);
  assign hit_evt = I_ReadEnable && (I_ReadAddr == KEYEVT_ADDR);

  always_comb begin
    rdata_d  = '0;
    rvalid_d = 1'b0;
    evt_clr  = '0;
    if (hit_sw) begin
      rdata_d  = DATA_WIDTH'(sw_sync_q);
      rvalid_d = 1'b1;
    end else if (hit_key) begin
      rdata_d  = DATA_WIDTH'(kstate_q);
      rvalid_d = 1'b1;
    end else if (hit_evt) begin
      rdata_d  = DATA_WIDTH'(evt_q);
      rvalid_d = 1'b1;
      evt_clr  = evt_q;
    end
  end

  // Set wins over the read-to-clear so an event arriving during the read is kept.
  always_comb begin
`ifdef MMIO_IN_RELEASE_EVT_EN
    evt_set = {rel_pulse, press};
`else
    evt_set = press;
`endif
    evt_d     = (evt_q & ~evt_clr) | evt_set;
    pending_d = |evt_q;
  end

  always_ff @(posedge I_CLOCK or negedge I_LOCK) begin
    if (!I_LOCK) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      key_meta_q <= '1;
      key_sync_q <= '1;
      kstate_q   <= {4{ST_UP}};
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      evt_q      <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
      key_meta_q <= key_meta_d;
      key_sync_q <= key_sync_d;
      kstate_q   <= kstate_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      evt_q      <= evt_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      pending_q  <= pending_d;
    end
  end

  assign O_ReadData        = rdata_q;
  assign O_ReadValid       = rvalid_q;
  assign O_KeyEventPending = pending_q;

endmodule

// File: doc/mmio_input_port.md
Name: mmio_input_port

Overview:
- Memory-mapped input peripheral for the 5-stage pipeline. It is the read-side counterpart of the LED/HEX output port already driven by the Memory stage.
- Synchronizes board switches (SW[9:0]) and pushbuttons (KEY[3:0]), debounces the keys and latches sticky key-press events.
- The Memory stage reads these values through a registered load interface.
- Clocked on the divided pipeline clock, alongside Fetch/Decode/Execute/Memory/Writeback.

Parameters:
- DATA_WIDTH, 16, width of the load data returned (matches REG_WIDTH).
- ADDR_WIDTH, 16, width of the load address.
- SW_ADDR, 16'hFF00, address of the switch register.
- KEY_ADDR, 16'hFF01, address of the debounced key-state register.
- KEYEVT_ADDR, 16'hFF02, address of the key-event register (read-to-clear).
- DEBOUNCE_CYCLES, 4, consecutive stable samples required to accept a key change (range 1..255).

Ports:
- I_CLOCK  in  1  pipeline clock.
- I_LOCK  in  1  asynchronous active-low reset; 0 = reset (same I_LOCK signal as the pipeline stages).
- I_SW  in  10  raw slide switches, asynchronous, 1 = on.
- I_KEY  in  4  raw pushbuttons, asynchronous, active-low (0 = pressed).
- I_ReadEnable  in  1  load request from the Memory stage this cycle.
- I_ReadAddr  in  ADDR_WIDTH  load address.
- O_ReadData  out  DATA_WIDTH  registered load data.
- O_ReadValid  out  1  high for one cycle when O_ReadData carries a hit.
- O_KeyEventPending  out  1  OR of all event bits (registered).

Behaviour:
- Reset (I_LOCK=0, asynchronous, any cycle, including mid-debounce or mid-read):
  - SW synchronizer flops = 0; KEY synchronizer flops = 1 (released).
  - Debounce counters = 0; all key FSMs = UP; event register = 0.
  - O_ReadData = 0, O_ReadValid = 0, O_KeyEventPending = 0.
- Synchronizers: 2-flop on every SW and KEY bit. Synchronized value = second flop. Input-to-debounce latency is 2 cycles.
- Debounce FSM, one per key, states UP and DOWN, with an 8-bit counter cnt:
  - Sample p = ~key_sync[i].
  - In UP: if p=1, cnt++; else cnt=0. When cnt reaches DEBOUNCE_CYCLES-1 and p=1: go to DOWN, cnt=0, pulse press[i].
  - In DOWN: symmetric with p=0; on reaching the threshold go to UP and pulse release[i].
  - A glitch shorter than DEBOUNCE_CYCLES resets cnt and causes no state change. Counter never wraps.
- Debounced state: kstate[i] = 1 in DOWN.
- Event register evt[3:0]:
  - evt_next = (evt & ~clr) | press.
  - clr = evt value returned by a hitting KEYEVT_ADDR read in this cycle, else 0.
  - A press in the same cycle as the clearing read keeps its bit set; set wins, so no event is lost.
- Read, 1-cycle latency:
  - On the edge where I_ReadEnable=1 and I_ReadAddr matches, the next cycle presents O_ReadValid=1 and:
    - SW_ADDR: {zeros, sw_sync[9:0]}.
    - KEY_ADDR: {zeros, kstate[3:0]}.
    - KEYEVT_ADDR: {zeros, evt[7:0]}, where evt[7:4] is defined under Optional Feature.
  - Miss or I_ReadEnable=0: O_ReadValid=0 and O_ReadData=0 next cycle.
  - Back-to-back reads are accepted every cycle. A second KEYEVT read sees only events that arrived after the first read.
- O_KeyEventPending: registered |evt; updates 1 cycle after evt changes.
- Unused upper data bits always read 0.

Optional Feature:
- Macro MMIO_IN_RELEASE_EVT_EN.
- Defined: evt is 8 bits. evt[7:4] capture release[3:0] with the same set-wins read-to-clear rule. O_KeyEventPending ORs all 8 bits.
- Undefined: no release event storage is built. Bits [7:4] of a KEYEVT read are 0, and only press events drive O_KeyEventPending.

Test Plan:
- Reset: I_LOCK=0 mid-debounce of KEY0 (cnt=2), then release reset -> all outputs 0, KEY0 FSM=UP, and a KEY_ADDR read returns 16'h0000.
- Switch read: I_SW=10'h2A5 held for 3 cycles, then read SW_ADDR -> next cycle O_ReadValid=1 and O_ReadData=16'h02A5. A read of 16'hFF07 -> O_ReadValid=0, O_ReadData=0.
- Debounce (DEBOUNCE_CYCLES=4):
  - KEY1 low for 3 cycles, then high -> kstate=0 and evt=0.
  - KEY1 low for 6 cycles -> kstate[1]=1 exactly 2+4 cycles after the falling edge, evt[1]=1, and O_KeyEventPending=1 one cycle later.
- Read-to-clear: after a KEY2 press, read KEYEVT_ADDR -> O_ReadData=16'h0004, then a second read -> 16'h0000 and O_KeyEventPending=0.
- Simultaneous: schedule KEY3's debounce acceptance in the same cycle as a KEYEVT read returning 16'h0001 -> evt afterwards = 4'b1000. The next read returns 16'h0008.
- Macro MMIO_IN_RELEASE_EVT_EN defined: press then release KEY0 (each ≥6 cycles), then read KEYEVT -> 16'h0011. With the macro undefined, the same sequence -> 16'h0001.
